// File: rtl/axa_undo_stack_pkg.sv
// Shared AXA definitions used by the undo buffer and the pipeline around it.
//   WORD       : width of one AXA word
//   UNDO_DEPTH : default undo history depth
//   op_e       : opcode encoding; op_pushes() marks opcodes that push undo history
//   il_type_e  : instruction-layout class
//   SIG_*      : error bit positions in the pipeline's sticky signal word
package axa_undo_stack_pkg;

  localparam int WORD       = 16;
  localparam int UNDO_DEPTH = 16;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_XOR  = 4'h3,
    OP_LD   = 4'h4,
    OP_ST   = 4'h5,
    OP_JMP  = 4'h6,
    OP_LAND = 4'h7,
    OP_UND  = 4'h8,
    OP_COM  = 4'h9
  } op_e;

  // Bit 3 of the opcode is reserved for "does not push"; below that, anything
  // that overwrites a register or jumps must save the old value.
  localparam int OP_PUSHES = 3;

  typedef enum logic [1:0] {
    IL_RR  = 2'd0,
    IL_RI  = 2'd1,
    IL_UND = 2'd2,
    IL_SYS = 2'd3
  } il_type_e;

  localparam int SIG_OVF = 0;
  localparam int SIG_UNF = 1;
  localparam int SIG_PKE = 2;

  function automatic logic op_pushes(input op_e op);
    logic [3:0] raw;
    raw = op;
    return (raw[OP_PUSHES] == 1'b0) && (op != OP_NOP);
  endfunction

endpackage

// File: rtl/axa_undo_mem.sv
// Undo storage: DEPTH x WIDTH array, one synchronous write port and two
// combinational read ports (top of stack and peek). Not reset, so it can be
// mapped onto a RAM later.
//   we/waddr/wdata : write port
//   raddr_top/rdata_top : read port for the top entry
//   raddr_pk/rdata_pk   : read port for indexed peeks
module axa_undo_mem import axa_undo_stack_pkg::*; #(
  parameter int WIDTH = WORD,
  parameter int DEPTH = UNDO_DEPTH,
  parameter int PTRW  = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTRW-1:0]  waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTRW-1:0]  raddr_top,
  output logic [WIDTH-1:0] rdata_top,
  input  logic [PTRW-1:0]  raddr_pk,
  output logic [WIDTH-1:0] rdata_pk
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata_top = mem_q[raddr_top];
  assign rdata_pk  = mem_q[raddr_pk];

endmodule

// File: rtl/axa_undo_stack.sv
// Undo stack for the reversible AXA pipeline. Circular history with
// occupancy tracking, overflow policy, underflow detection and registered
// indexed peeks relative to the top of stack.
//   clk, reset (async, active low)
//   push/push_data, pop, commit      : stack operations
//   top_data                         : combinational top entry (0 when empty)
//   peek_req/peek_idx -> peek_data/peek_valid/peek_err (one cycle later)
//   count/empty/full                 : occupancy
//   overflow/underflow               : single-cycle error pulses
module axa_undo_stack import axa_undo_stack_pkg::*; #(
  parameter int WIDTH     = WORD,
  parameter int DEPTH     = UNDO_DEPTH,
  parameter int PTRW      = $clog2(DEPTH),
  parameter bit OVERWRITE = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] top_data,
  input  logic             peek_req,
  input  logic [PTRW-1:0]  peek_idx,
  output logic [WIDTH-1:0] peek_data,
  output logic             peek_valid,
  output logic             peek_err,
  input  logic             commit,
  output logic [PTRW:0]    count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [PTRW:0]   CNT_MAX = (PTRW+1)'(DEPTH);
  localparam logic [PTRW-1:0] ONE     = PTRW'(1);

  logic [PTRW-1:0]  sp_q, sp_d;
  logic [PTRW:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic [WIDTH-1:0] pk_data_q;
  logic             pk_vld_q, pk_err_q, pk_err;
  logic             we;
  logic [PTRW-1:0]  waddr, top_addr, pk_addr;
  logic [WIDTH-1:0] rd_top, rd_pk;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CNT_MAX);
  assign top_addr = sp_q - ONE;
  assign pk_addr  = sp_q - ONE - peek_idx;
  assign pk_err   = ({1'b0, peek_idx} >= cnt_q);

  axa_undo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTRW(PTRW)) u_mem (
    .clk       (clk),
    .we        (we),
    .waddr     (waddr),
    .wdata     (push_data),
    .raddr_top (top_addr),
    .rdata_top (rd_top),
    .raddr_pk  (pk_addr),
    .rdata_pk  (rd_pk)
  );

  // Commit wins over everything; a push alongside it lands on the fresh
  // empty stack. push+pop on a non-empty stack is an in-place top replace.
  always_comb begin
    sp_d  = sp_q;
    cnt_d = cnt_q;
    we    = 1'b0;
    waddr = sp_q;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    if (commit) begin
      cnt_d = '0;
      if (push) begin
        we    = 1'b1;
        sp_d  = sp_q + ONE;
        cnt_d = (PTRW+1)'(1);
      end
    end else if (push && pop) begin
      we = 1'b1;
      if (!empty) begin
        waddr = top_addr;
      end else begin
        unf_d = 1'b1;
        sp_d  = sp_q + ONE;
        cnt_d = (PTRW+1)'(1);
      end
    end else if (push) begin
      if (!full) begin
        we    = 1'b1;
        sp_d  = sp_q + ONE;
        cnt_d = cnt_q + 1'b1;
      end else begin
        ovf_d = 1'b1;
        if (OVERWRITE) begin
          we   = 1'b1;
          sp_d = sp_q + ONE;
        end
      end
    end else if (pop) begin
      if (!empty) begin
        sp_d  = sp_q - ONE;
        cnt_d = cnt_q - 1'b1;
      end else begin
        unf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp_q      <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      pk_data_q <= '0;
      pk_vld_q  <= 1'b0;
      pk_err_q  <= 1'b0;
    end else begin
      sp_q     <= sp_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      pk_vld_q <= peek_req;
      pk_err_q <= peek_req && pk_err;
      // Peek reads pre-edge sp, so it never sees this cycle's push/pop.
      if (peek_req) pk_data_q <= pk_err ? '0 : rd_pk;
    end
  end

  assign top_data   = empty ? '0 : rd_top;
  assign count      = cnt_q;
  assign overflow   = ovf_q;
  assign underflow  = unf_q;
  assign peek_data  = pk_data_q;
  assign peek_valid = pk_vld_q;
  assign peek_err   = pk_err_q;

endmodule

// File: tb/tb_axa_undo_stack.sv
module tb_axa_undo_stack;
  localparam int W = 16;
  localparam int D = 4;
  localparam int P = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic push = 1'b0, pop = 1'b0, peek_req = 1'b0, commit = 1'b0;
  logic [W-1:0] push_data = '0;
  logic [P-1:0] peek_idx = '0;

  logic [W-1:0] top_a, pd_a, top_b, pd_b;
  logic         pv_a, pe_a, em_a, fu_a, ov_a, un_a;
  logic         pv_b, pe_b, em_b, fu_b, ov_b, un_b;
  logic [P:0]   cnt_a, cnt_b;

  int errors = 0;
  int checks = 0;
  logic [W:0] exp_q [$];   // {peek_err, peek_data} expected from dut a

  always #5 clk = ~clk;

  axa_undo_stack #(.WIDTH(W), .DEPTH(D), .PTRW(P), .OVERWRITE(1'b1)) dut_a (
    .clk(clk), .reset(reset), .push(push), .push_data(push_data), .pop(pop),
    .top_data(top_a), .peek_req(peek_req), .peek_idx(peek_idx),
    .peek_data(pd_a), .peek_valid(pv_a), .peek_err(pe_a), .commit(commit),
    .count(cnt_a), .empty(em_a), .full(fu_a), .overflow(ov_a), .underflow(un_a));

  axa_undo_stack #(.WIDTH(W), .DEPTH(D), .PTRW(P), .OVERWRITE(1'b0)) dut_b (
    .clk(clk), .reset(reset), .push(push), .push_data(push_data), .pop(pop),
    .top_data(top_b), .peek_req(peek_req), .peek_idx(peek_idx),
    .peek_data(pd_b), .peek_valid(pv_b), .peek_err(pe_b), .commit(commit),
    .count(cnt_b), .empty(em_b), .full(fu_b), .overflow(ov_b), .underflow(un_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Peek monitor: compares every peek_valid against the scoreboard.
  always @(negedge clk) begin
    if (pv_a) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL peek_unexpected: got %h expected none", {pe_a, pd_a});
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        if ({pe_a, pd_a} !== e) begin
          errors++;
          $display("FAIL peek: got err=%b data=%h expected err=%b data=%h",
                   pe_a, pd_a, e[W], e[W-1:0]);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; peek_req = 1'b0; commit = 1'b0;
  endtask

  task automatic do_push(input logic [W-1:0] d);
    push = 1'b1; push_data = d;
    cyc();
  endtask

  task automatic do_peek(input logic [P-1:0] idx, input logic err, input logic [W-1:0] d);
    peek_req = 1'b1; peek_idx = idx;
    exp_q.push_back({err, d});
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    #10 reset = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset state, checked while reset is held.
    #3;
    chk("rst_count", 32'(cnt_a), 0);
    chk("rst_empty", 32'(em_a), 1);
    chk("rst_full", 32'(fu_a), 0);
    chk("rst_top", 32'(top_a), 0);
    chk("rst_flags", {pv_a, pe_a, ov_a, un_a}, 0);
    #10 reset = 1'b1;
    @(posedge clk); #1;

    // Basic pushes and peeks.
    do_push(16'h0011); do_push(16'h0022); do_push(16'h0033);
    chk("p3_count", 32'(cnt_a), 3);
    chk("p3_top", 32'(top_a), 32'h0033);
    do_peek(2'd2, 1'b0, 16'h0011); cyc();
    do_peek(2'd3, 1'b1, 16'h0000); cyc();
    cyc();

    // Overflow under both policies.
    do_reset();
    for (int i = 1; i <= 4; i++) do_push(16'h00A0 + 16'(i));
    chk("full_a", 32'(fu_a), 1);
    chk("ov_before", 32'(ov_a), 0);
    do_push(16'h00A5);
    chk("ov_a", 32'(ov_a), 1);
    chk("ov_b", 32'(ov_b), 1);
    chk("ovf_cnt_a", 32'(cnt_a), 4);
    chk("ovf_cnt_b", 32'(cnt_b), 4);
    chk("ovf_top_a", 32'(top_a), 32'h00A5);
    chk("ovf_top_b", 32'(top_b), 32'h00A4);
    cyc();
    chk("ov_pulse", {ov_a, ov_b}, 0);
    for (int i = 0; i < 4; i++) begin
      chk("pop_top_a", 32'(top_a), 32'h00A5 - 32'(i));
      chk("pop_top_b", 32'(top_b), 32'h00A4 - 32'(i));
      pop = 1'b1; cyc();
    end
    chk("drain_cnt", 32'(cnt_a), 0);
    chk("drain_top", 32'(top_a), 0);

    // Underflow.
    pop = 1'b1; cyc();
    chk("unf", 32'(un_a), 1);
    chk("unf_cnt", 32'(cnt_a), 0);
    cyc();
    chk("unf_pulse", 32'(un_a), 0);
    push = 1'b1; push_data = 16'h0055; pop = 1'b1; cyc();
    chk("pp_empty_unf", 32'(un_a), 1);
    chk("pp_empty_cnt", 32'(cnt_a), 1);
    chk("pp_empty_top", 32'(top_a), 32'h0055);

    // Replace top with simultaneous push+pop; peek sees pre-edge top.
    do_reset();
    do_push(16'h0011); do_push(16'h0022);
    push = 1'b1; push_data = 16'h0099; pop = 1'b1;
    do_peek(2'd0, 1'b0, 16'h0022); cyc();
    chk("repl_cnt", 32'(cnt_a), 2);
    chk("repl_top", 32'(top_a), 32'h0099);
    chk("repl_unf", 32'(un_a), 0);

    // Commit + push.
    do_push(16'h0033);
    chk("pre_com_cnt", 32'(cnt_a), 3);
    commit = 1'b1; push = 1'b1; push_data = 16'h0044; pop = 1'b1; cyc();
    chk("com_cnt", 32'(cnt_a), 1);
    chk("com_top", 32'(top_a), 32'h0044);
    chk("com_unf", 32'(un_a), 0);
    do_peek(2'd1, 1'b1, 16'h0000); cyc();
    do_peek(2'd0, 1'b0, 16'h0044); cyc();

    // Asynchronous reset in the middle of a push.
    do_push(16'h0066);
    push = 1'b1; push_data = 16'h0077;
    #2 reset = 1'b0;
    #1;
    chk("async_rst_cnt", 32'(cnt_a), 0);
    chk("async_rst_empty", 32'(em_a), 1);
    #4 reset = 1'b1;
    @(posedge clk); #1;
    push = 1'b0;
    chk("post_rst_cnt", 32'(cnt_a), 1);
    chk("post_rst_top", 32'(top_a), 32'h0077);

    cyc(); cyc();
    chk("peek_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected done");
    $fatal(1);
  end

endmodule

// File: doc/axa_undo_stack.md
Name: axa_undo_stack

Overview:
Parametrised undo buffer for the reversible AXA pipeline. It replaces the fixed 16-entry wrapping array and bare pointer with a module that tracks occupancy, handles overflow by policy, detects underflow, and serves indexed reads from the top of stack for Und-type operands. Stage 2 pushes into it and reads peeks from it. The ALU stage pops it for reverse-execution restores. Commit (com) discards all history.

Parameters:
WIDTH, 16, entry width in bits (one AXA word)
DEPTH, 16, number of entries; power of two, >= 2
PTRW, $clog2(DEPTH), pointer and peek-index width
OVERWRITE, 1, 1 = push on full overwrites oldest entry; 0 = push on full is dropped

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
push  in  1  write push_data as the new top
push_data  in  WIDTH  value to push (dst register or land's saved PC)
pop  in  1  remove top entry
top_data  out  WIDTH  combinational entry at top of stack; 0 when empty
peek_req  in  1  request an indexed read
peek_idx  in  PTRW  offset below top (0 = top)
peek_data  out  WIDTH  registered peek result
peek_valid  out  1  pulses high one cycle after peek_req
peek_err  out  1  pulses with peek_valid when peek_idx >= count
commit  in  1  discard all entries
count  out  PTRW+1  current occupancy, 0..DEPTH
empty  out  1  count == 0
full  out  1  count == DEPTH
overflow  out  1  one-cycle pulse on push while full
underflow  out  1  one-cycle pulse on pop while empty

Behaviour:
- Reset (reset low, asynchronous): sp=0, count=0, and peek_data, peek_valid, peek_err, overflow and underflow all =0. Storage contents are not cleared. empty=1, full=0, top_data=0.
- Storage: circular array mem[DEPTH]. sp is a PTRW-bit write pointer that wraps modulo DEPTH. The top entry is mem[sp-1 mod DEPTH].
- Every input is sampled on the rising clk edge. All state updates land in the same edge (latency 1).
- Per-cycle priority, evaluated on the pre-edge state:
  - commit: count<=0. sp is unchanged. A pop in the same cycle is ignored and does not assert underflow. A push in the same cycle is then applied to the empty stack, giving count=1.
  - push & pop & !empty: replace the top entry, mem[sp-1]<=push_data. count and sp are unchanged.
  - push & pop & empty: pop is ignored and underflow pulses. The push is performed.
  - push only, not full: mem[sp]<=push_data, sp+=1, count+=1.
  - push only, full, OVERWRITE=1: mem[sp]<=push_data, sp+=1, count stays DEPTH (the oldest entry is lost). overflow pulses.
  - push only, full, OVERWRITE=0: no write, no state change. overflow pulses.
  - pop only, !empty: sp-=1, count-=1. The entry is not cleared.
  - pop only, empty: no state change. underflow pulses.
- Peek:
  - peek_data <= mem[sp-1-peek_idx mod DEPTH], using the pre-edge sp. A peek therefore sees the state before any push or pop in the same cycle.
  - peek_valid pulses the next cycle.
  - peek_err = (peek_idx >= count). When peek_err is set, peek_data=0.
  - With no peek_req, peek_valid=0 and peek_data holds its value.
- overflow and underflow are single-cycle pulses. They are not sticky; the error latching belongs to the pipeline.
- top_data, empty and full are combinational from the registered count and sp.
- Width rules: all pointer arithmetic is PTRW bits and wraps. count is PTRW+1 bits and never exceeds DEPTH or goes below 0.
- Reset asserted mid-sequence takes effect immediately. The first edge after reset deasserts behaves as an empty stack.

Decomposition:
- Shared axa package holds: WORD width, the OP codes and OP_PUSHES bit, the ILType codes, the SIG* error bits, and the default UNDO_DEPTH constant.
- One natural sub-module: axa_undo_mem. It is a DEPTH x WIDTH array with one write port and two read ports (top and peek), so the storage can later be mapped to RAM.
- Pointer, count and flag logic stay in axa_undo_stack.

Test Plan:
All scenarios use DEPTH=4, WIDTH=16.
- Reset, then push 0x0011, 0x0022, 0x0033 -> count=3, top_data=0x0033. Peek idx 2 -> next cycle peek_data=0x0011, peek_err=0.
- OVERWRITE=1: push 0xA1..0xA5 -> the 5th push pulses overflow, count=4. Popping 4 times gives top_data 0xA5, 0xA4, 0xA3, 0xA2. 0xA1 is lost.
- OVERWRITE=0, same pushes -> overflow pulses, count=4, top_data=0xA4.
- Pop when empty -> underflow=1 for exactly one cycle, count=0. push+pop together when empty -> underflow pulses, count=1, top_data=push_data.
- With count=2 and top 0x0022, push 0x0099 + pop in the same cycle -> count=2, top_data=0x0099. A peek idx 0 in that same cycle returns 0x0022.
- With count=3, commit+push 0x0044 in one cycle -> count=1, top_data=0x0044. Peek idx 1 -> peek_err=1, peek_data=0. Drive reset low mid-push -> count=0 immediately, without waiting for a clock edge.
